// File: rtl/ctx_stack.sv
// Interrupt-context stack: saves {ie, V, N, C, Z, pc} on interrupt entry and
// replays it on RETI through the ALU flag-restore port with a one-cycle strobe.
module ctx_stack #(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_WIDTH-1:0]          pc_in,
    input  logic                         flag_z,
    input  logic                         flag_c,
    input  logic                         flag_n,
    input  logic                         flag_v,
    input  logic                         ie_in,
    input  logic                         err_clr,
    output logic [3:0]                   flag_dout,
    output logic                         flag_wr,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic                         ie_out,
    output logic                         busy,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf_err,
    output logic                         unf_err
);

    // Flag bit positions on the ALU flag-restore bus
    localparam int Z_FLAG = 0;
    localparam int C_FLAG = 1;
    localparam int N_FLAG = 2;
    localparam int V_FLAG = 3;

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = PC_WIDTH + 5;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP_RD = 2'd1,
        POP_WR = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [W-1:0]      mem_r [DEPTH];
    logic [W-1:0]      rd_word_r;
    logic [W-1:0]      wr_word_s;
    logic [LW-1:0]     sp_r;
    logic [LW-1:0]     sp_nxt_s;
    logic [AW-1:0]     wr_addr_s;
    logic [AW-1:0]     rd_addr_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              full_r;
    logic              empty_r;
    logic              ovf_r;
    logic              unf_r;
    logic              flag_wr_r;
    logic              busy_r;
    logic [3:0]        flag_dout_r;
    logic [PC_WIDTH-1:0] pc_out_r;
    logic              ie_out_r;

    // Accept/reject decisions, error detection and stack pointer update
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        sp_nxt_s  = sp_r;
        wr_word_s = {ie_in, flag_v, flag_n, flag_c, flag_z, pc_in};
        wr_addr_s = AW'(sp_r);
        rd_addr_s = AW'(sp_r - ONE_L);
        if (state_r == IDLE) begin
            push_ok_s = push & ~full_r;
            pop_ok_s  = pop & ~push & ~empty_r;
            ovf_set_s = push & full_r;
            // A simultaneous push wins; the pop is dropped and flagged
            unf_set_s = pop & (push | empty_r);
        end else begin
            ovf_set_s = push;
            unf_set_s = pop;
        end
        if (push_ok_s) begin
            sp_nxt_s = sp_r + ONE_L;
        end else if (pop_ok_s) begin
            sp_nxt_s = sp_r - ONE_L;
        end else begin
            sp_nxt_s = sp_r;
        end
    end

    // Pop sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_ok_s) begin
                    state_nxt_s = POP_RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            POP_RD:  state_nxt_s = POP_WR;
            POP_WR:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pop sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Context storage with registered read; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_addr_s] <= wr_word_s;
        end
        if (pop_ok_s) begin
            rd_word_r <= mem_r[rd_addr_s];
        end
    end

    // Level, status, sticky errors and restore outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r        <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            flag_wr_r   <= 1'b0;
            busy_r      <= 1'b0;
            flag_dout_r <= 4'b0000;
            pc_out_r    <= '0;
            ie_out_r    <= 1'b0;
        end else begin
            sp_r      <= sp_nxt_s;
            full_r    <= (sp_nxt_s == DEPTH_L);
            empty_r   <= (sp_nxt_s == '0);
            busy_r    <= (state_nxt_s != IDLE);
            flag_wr_r <= (state_r == POP_RD);
            // A new error in the clear cycle keeps the bit set
            ovf_r     <= ovf_set_s | (ovf_r & ~err_clr);
            unf_r     <= unf_set_s | (unf_r & ~err_clr);
            if (state_r == POP_RD) begin
                pc_out_r            <= rd_word_r[PC_WIDTH-1:0];
                flag_dout_r[Z_FLAG] <= rd_word_r[PC_WIDTH];
                flag_dout_r[C_FLAG] <= rd_word_r[PC_WIDTH+1];
                flag_dout_r[N_FLAG] <= rd_word_r[PC_WIDTH+2];
                flag_dout_r[V_FLAG] <= rd_word_r[PC_WIDTH+3];
                ie_out_r            <= rd_word_r[PC_WIDTH+4];
            end
        end
    end

    assign flag_dout = flag_dout_r;
    assign flag_wr   = flag_wr_r;
    assign pc_out    = pc_out_r;
    assign ie_out    = ie_out_r;
    assign busy      = busy_r;
    assign empty     = empty_r;
    assign full      = full_r;
    assign level     = sp_r;
    assign ovf_err   = ovf_r;
    assign unf_err   = unf_r;

endmodule

// File: tb/tb_ctx_stack.sv
// Directed bench for ctx_stack: reset, round trip, LIFO/full, underflow and
// collision cases, each checked with an immediate assertion.
module tb_ctx_stack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] pc_in = 8'h00;
    logic       flag_z = 1'b0;
    logic       flag_c = 1'b0;
    logic       flag_n = 1'b0;
    logic       flag_v = 1'b0;
    logic       ie_in = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] flag_dout;
    logic       flag_wr;
    logic [7:0] pc_out;
    logic       ie_out;
    logic       busy;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       ovf_err;
    logic       unf_err;

    int n_assert = 0;
    int n_fail   = 0;

    ctx_stack #(.DEPTH(16), .PC_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pc_in(pc_in),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
        .ie_in(ie_in), .err_clr(err_clr), .flag_dout(flag_dout),
        .flag_wr(flag_wr), .pc_out(pc_out), .ie_out(ie_out), .busy(busy),
        .empty(empty), .full(full), .level(level), .ovf_err(ovf_err),
        .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctx(input logic [7:0] pc, input logic [3:0] f, input logic ie);
        pc_in  = pc;
        flag_z = f[0];
        flag_c = f[1];
        flag_n = f[2];
        flag_v = f[3];
        ie_in  = ie;
    endtask

    initial begin
        // Reset asserted mid-cycle, outputs checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_flag_wr", flag_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_flag_dout", flag_dout, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_ie_out", ie_out, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_unf", unf_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_level", level, 0);
        check("idle_empty", empty, 1);
        check("idle_flag_wr", flag_wr, 0);
        check("idle_busy", busy, 0);
        check("idle_errs", {ovf_err, unf_err}, 0);

        // Single round trip: Z=1 C=0 N=1 V=0 -> flag_dout 4'b0101
        push = 1'b1;
        set_ctx(8'h3A, 4'b0101, 1'b1);
        tick();
        push = 1'b0;
        set_ctx(8'h00, 4'b0000, 1'b0);
        check("rt_level1", level, 1);
        check("rt_empty0", empty, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("rt_busy_e0", busy, 1);
        check("rt_level0", level, 0);
        check("rt_nowr_e0", flag_wr, 0);
        tick();
        check("rt_wr_e1", flag_wr, 1);
        check("rt_pc", pc_out, 8'h3A);
        check("rt_flags", flag_dout, 4'b0101);
        check("rt_ie", ie_out, 1);
        tick();
        check("rt_wr_e2", flag_wr, 0);
        check("rt_busy_e2", busy, 0);
        check("rt_pc_hold", pc_out, 8'h3A);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            set_ctx(8'(i), 4'(i), i[0]);
            tick();
        end
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        set_ctx(8'hEE, 4'hF, 1'b1);
        tick();
        push = 1'b0;
        check("ovf_err", ovf_err, 1);
        check("ovf_level", level, 16);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", ovf_err, 0);

        // Drain in LIFO order
        for (int k = 15; k >= 0; k--) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
            tick();
            check("lifo_wr", flag_wr, 1);
            check("lifo_pc", pc_out, k);
            check("lifo_flags", flag_dout, k & 15);
            check("lifo_ie", ie_out, k & 1);
            tick();
        end
        check("drain_empty", empty, 1);
        check("drain_level", level, 0);
        check("drain_full", full, 0);

        // Underflow, and error set winning over a simultaneous clear
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("unf_err", unf_err, 1);
        check("unf_busy", busy, 0);
        tick();
        check("unf_nowr", flag_wr, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unf_clr", unf_err, 0);
        pop = 1'b1;
        err_clr = 1'b1;
        tick();
        pop = 1'b0;
        err_clr = 1'b0;
        check("unf_set_wins", unf_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Push and pop together: push wins, pop flagged
        push = 1'b1;
        pop  = 1'b1;
        set_ctx(8'h55, 4'b1010, 1'b0);
        tick();
        push = 1'b0;
        pop  = 1'b0;
        check("pp_level", level, 1);
        check("pp_unf", unf_err, 1);
        check("pp_busy", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Push while busy is ignored
        pop = 1'b1;
        tick();
        pop  = 1'b0;
        push = 1'b1;
        set_ctx(8'h77, 4'b0000, 1'b1);
        tick();
        push = 1'b0;
        check("busy_push_ovf", ovf_err, 1);
        check("busy_push_level", level, 0);
        check("busy_pop_wr", flag_wr, 1);
        check("busy_pop_pc", pc_out, 8'h55);
        check("busy_pop_flags", flag_dout, 4'b1010);
        tick();
        check("busy_done_level", level, 0);
        check("busy_done_empty", empty, 1);

        // Reset while in POP_RD aborts the restore
        push = 1'b1;
        set_ctx(8'h99, 4'b1111, 1'b1);
        tick();
        push = 1'b0;
        pop  = 1'b1;
        tick();
        pop = 1'b0;
        check("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr", flag_wr, 0);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        check("abort_pc", pc_out, 0);
        @(posedge clk);
        #1;
        check("abort_wr_next", flag_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_idle_wr", flag_wr, 0);
        check("abort_idle_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
